dmac_ioregister_nch: RTL and testbench

DMAC_IOREGISTER_NCH -- requirements
Module: dmac_ioregister_nch

---
 rtl/dmac_ioreg_pkg.sv | 21 ++
 rtl/dmac_ioreg_fifo.sv | 55 +++++
 rtl/dmac_ioregister_nch.sv | 174 +++++++++++++++++
 tb/tb_dmac_ioregister_nch.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_ioreg_pkg.sv
// Shared defaults and helpers for the DMA controller I/O register block.
package dmac_ioreg_pkg;

   localparam int unsigned DEF_W_D             = 32;
   localparam int unsigned DEF_NUM_CH          = 4;
   localparam int unsigned DEF_FIFO_ADDR_WIDTH = 2;

   // Ceiling log2, used to size channel indices from the channel count.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dmac_ioreg_fifo.sv
// Count-based synchronous FIFO holding inbound words for one channel.
module dmac_ioreg_fifo
   import dmac_ioreg_pkg::*;
#(
   parameter int unsigned W_D             = DEF_W_D,
   parameter int unsigned FIFO_ADDR_WIDTH = DEF_FIFO_ADDR_WIDTH
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       push,
   input  logic [W_D-1:0]             push_data,
   input  logic                       pop,
   output logic [W_D-1:0]             head_c,
   output logic [FIFO_ADDR_WIDTH:0]   count,
   output logic                       full_c,
   output logic                       empty_c
);

   localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
   localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;

   logic [W_D-1:0]             mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
   logic                       push_ok_c;
   logic                       pop_ok_c;

   assign full_c    = (count == CNT_W'(DEPTH));
   assign empty_c   = (count == '0);
   assign push_ok_c = push && !full_c;
   assign pop_ok_c  = pop && !empty_c;
   assign head_c    = mem[rd_ptr];

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok_c) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
         if (pop_ok_c)  rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
         case ({push_ok_c, pop_ok_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok_c) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dmac_ioregister_nch.sv
// Multi-channel I/O register: inbound per-channel FIFOs read by the control
// thread, outbound single-word slots drained round-robin to a downstream FIFO.
module dmac_ioregister_nch
   import dmac_ioreg_pkg::*;
#(
   parameter int unsigned W_D             = DEF_W_D,
   parameter int unsigned NUM_CH          = DEF_NUM_CH,
   parameter int unsigned W_CH            = clog2(NUM_CH),
   parameter int unsigned FIFO_ADDR_WIDTH = DEF_FIFO_ADDR_WIDTH
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [W_D-1:0]    ext_write_data,
   input  logic [W_CH-1:0]   ext_write_ch,
   input  logic              ext_write_empty,
   output logic              ext_write_deq,
   output logic [W_D-1:0]    ext_read_data,
   output logic [W_CH-1:0]   ext_read_ch,
   output logic              ext_read_enq,
   input  logic              ext_read_almost_full,
   input  logic [W_CH-1:0]   coram_ch,
   input  logic [W_D-1:0]    coram_d,
   input  logic              coram_we,
   input  logic              coram_re,
   output logic [W_D-1:0]    coram_q,
   output logic              coram_q_valid,
   output logic [NUM_CH-1:0] coram_rx_avail,
   output logic [NUM_CH-1:0] coram_tx_busy,
   output logic [NUM_CH-1:0] coram_tx_overflow
);

   localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;

   logic [NUM_CH-1:0] fifo_push_c;
   logic [NUM_CH-1:0] fifo_pop_c;
   logic [NUM_CH-1:0] fifo_full_c;
   logic [NUM_CH-1:0] fifo_empty_c;
   logic [W_D-1:0]    fifo_head_c [NUM_CH];
   logic [CNT_W-1:0]  fifo_count  [NUM_CH];

   logic              wr_full_sel_c;
   logic              rx_empty_sel_c;
   logic [W_D-1:0]    head_sel_c;
   logic              coram_pop_c;

   logic [W_D-1:0]    slot_data [NUM_CH];
   logic [NUM_CH-1:0] slot_busy;
   logic [NUM_CH-1:0] tx_overflow;
   logic [NUM_CH-1:0] slot_we_c;
   logic [NUM_CH-1:0] slot_drop_c;
   logic [W_CH-1:0]   rr_ptr;
   logic [W_CH-1:0]   scan_idx_c;
   logic [W_CH-1:0]   grant_idx_c;
   logic              grant_vld_c;

   function automatic logic [W_CH-1:0] ch_add(input logic [W_CH-1:0] base,
                                              input int unsigned     k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= NUM_CH) s = s - NUM_CH;
      return W_CH'(s);
   endfunction

   for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
      dmac_ioreg_fifo #(
         .W_D             (W_D),
         .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
      ) u_fifo (
         .CLK       (CLK),
         .RST       (RST),
         .push      (fifo_push_c[g]),
         .push_data (ext_write_data),
         .pop       (fifo_pop_c[g]),
         .head_c    (fifo_head_c[g]),
         .count     (fifo_count[g]),
         .full_c    (fifo_full_c[g]),
         .empty_c   (fifo_empty_c[g])
      );
      assign coram_rx_avail[g] = (fifo_count[g] != '0);
   end

   // Channel select for the inbound side; an unmapped channel index never accepts.
   always_comb begin
      wr_full_sel_c  = 1'b1;
      rx_empty_sel_c = 1'b1;
      head_sel_c     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ext_write_ch == W_CH'(i)) wr_full_sel_c = fifo_full_c[i];
         if (coram_ch == W_CH'(i)) begin
            rx_empty_sel_c = fifo_empty_c[i];
            head_sel_c     = fifo_head_c[i];
         end
      end
   end

   assign ext_write_deq = RST && !ext_write_empty && !wr_full_sel_c;
   assign coram_pop_c   = RST && coram_re && !rx_empty_sel_c;

   always_comb begin
      fifo_push_c = '0;
      fifo_pop_c  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         fifo_push_c[i] = ext_write_deq && (ext_write_ch == W_CH'(i));
         fifo_pop_c[i]  = coram_pop_c && (coram_ch == W_CH'(i));
      end
   end

   // Round-robin: first busy slot at or after rr_ptr, stalled by backpressure.
   always_comb begin
      grant_vld_c = 1'b0;
      grant_idx_c = '0;
      scan_idx_c  = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         scan_idx_c = ch_add(rr_ptr, k);
         if (!grant_vld_c && !ext_read_almost_full && slot_busy[scan_idx_c]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = scan_idx_c;
         end
      end
   end

   // A slot being drained this cycle may be refilled in the same cycle.
   always_comb begin
      slot_we_c   = '0;
      slot_drop_c = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (coram_we && (coram_ch == W_CH'(i))) begin
            if (!slot_busy[i] || (grant_vld_c && (grant_idx_c == W_CH'(i))))
               slot_we_c[i] = 1'b1;
            else
               slot_drop_c[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         slot_busy     <= '0;
         tx_overflow   <= '0;
         rr_ptr        <= '0;
         ext_read_enq  <= 1'b0;
         ext_read_data <= '0;
         ext_read_ch   <= '0;
         coram_q       <= '0;
         coram_q_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (slot_we_c[i])
               slot_busy[i] <= 1'b1;
            else if (grant_vld_c && (grant_idx_c == W_CH'(i)))
               slot_busy[i] <= 1'b0;
            if (slot_drop_c[i]) tx_overflow[i] <= 1'b1;
         end
         ext_read_enq <= grant_vld_c;
         if (grant_vld_c) begin
            ext_read_data <= slot_data[grant_idx_c];
            ext_read_ch   <= grant_idx_c;
            rr_ptr        <= ch_add(grant_idx_c, 1);
         end
         coram_q_valid <= coram_pop_c;
         if (coram_pop_c) coram_q <= head_sel_c;
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (slot_we_c[i]) slot_data[i] <= coram_d;
      end
   end

   assign coram_tx_busy     = slot_busy;
   assign coram_tx_overflow = tx_overflow;

endmodule

// File: tb/tb_dmac_ioregister_nch.sv
// Scoreboard bench for dmac_ioregister_nch: expected read returns and
// outbound words are queued when stimulus is driven and matched on output.
module tb_dmac_ioregister_nch;

   localparam int unsigned W_D    = 32;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned W_CH   = 2;
   localparam int unsigned FAW    = 2;

   logic              CLK = 1'b0;
   logic              RST;
   logic [W_D-1:0]    ext_write_data;
   logic [W_CH-1:0]   ext_write_ch;
   logic              ext_write_empty;
   logic              ext_write_deq;
   logic [W_D-1:0]    ext_read_data;
   logic [W_CH-1:0]   ext_read_ch;
   logic              ext_read_enq;
   logic              ext_read_almost_full;
   logic [W_CH-1:0]   coram_ch;
   logic [W_D-1:0]    coram_d;
   logic              coram_we;
   logic              coram_re;
   logic [W_D-1:0]    coram_q;
   logic              coram_q_valid;
   logic [NUM_CH-1:0] coram_rx_avail;
   logic [NUM_CH-1:0] coram_tx_busy;
   logic [NUM_CH-1:0] coram_tx_overflow;

   dmac_ioregister_nch #(
      .W_D             (W_D),
      .NUM_CH          (NUM_CH),
      .W_CH            (W_CH),
      .FIFO_ADDR_WIDTH (FAW)
   ) dut (
      .CLK                  (CLK),
      .RST                  (RST),
      .ext_write_data       (ext_write_data),
      .ext_write_ch         (ext_write_ch),
      .ext_write_empty      (ext_write_empty),
      .ext_write_deq        (ext_write_deq),
      .ext_read_data        (ext_read_data),
      .ext_read_ch          (ext_read_ch),
      .ext_read_enq         (ext_read_enq),
      .ext_read_almost_full (ext_read_almost_full),
      .coram_ch             (coram_ch),
      .coram_d              (coram_d),
      .coram_we             (coram_we),
      .coram_re             (coram_re),
      .coram_q              (coram_q),
      .coram_q_valid        (coram_q_valid),
      .coram_rx_avail       (coram_rx_avail),
      .coram_tx_busy        (coram_tx_busy),
      .coram_tx_overflow    (coram_tx_overflow)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int              cyc;
      logic [W_CH-1:0] ch;
      logic [W_D-1:0]  data;
   } exp_t;

   exp_t           q_exp  [$];
   exp_t           rd_exp [$];
   exp_t           mon_q;
   exp_t           mon_rd;
   int             n_chk  = 0;
   int             n_pass = 0;
   int             cyc    = 0;
   logic [W_D-1:0] last_q;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      else
         n_pass++;
   endtask

   // Match DUT outputs against the scoreboard mid-cycle.
   always @(negedge CLK) begin
      if (coram_q_valid) begin
         if (q_exp.size() == 0) begin
            chk("coram_q_unexpected", coram_q, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            mon_q = q_exp.pop_front();
            chk("coram_q_data", coram_q, mon_q.data);
            chk("coram_q_cycle", cyc, mon_q.cyc);
         end
      end
      if (ext_read_enq) begin
         if (rd_exp.size() == 0) begin
            chk("ext_read_unexpected", {ext_read_ch, ext_read_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            mon_rd = rd_exp.pop_front();
            chk("ext_read_ch", ext_read_ch, mon_rd.ch);
            chk("ext_read_data", ext_read_data, mon_rd.data);
            chk("ext_read_cycle", cyc, mon_rd.cyc);
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic exp_q(input logic [W_D-1:0] d);
      q_exp.push_back('{cyc: cyc + 1, ch: '0, data: d});
      last_q = d;
   endtask

   task automatic exp_rd(input int lat, input logic [W_CH-1:0] ch, input logic [W_D-1:0] d);
      rd_exp.push_back('{cyc: cyc + lat, ch: ch, data: d});
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((q_exp.size() != 0 || rd_exp.size() != 0) && n < 20) begin
         step();
         n++;
      end
      chk(tag, q_exp.size() + rd_exp.size(), 0);
   endtask

   task automatic ext_push(input logic [W_CH-1:0] ch, input logic [W_D-1:0] d, input string tag);
      ext_write_empty = 1'b0;
      ext_write_ch    = ch;
      ext_write_data  = d;
      @(negedge CLK);
      chk(tag, ext_write_deq, 1);
      step();
   endtask

   task automatic coram_read(input logic [W_CH-1:0] ch, input logic [W_D-1:0] d);
      coram_re = 1'b1;
      coram_ch = ch;
      exp_q(d);
      step();
      coram_re = 1'b0;
   endtask

   task automatic coram_write(input logic [W_CH-1:0] ch, input logic [W_D-1:0] d);
      coram_we = 1'b1;
      coram_ch = ch;
      coram_d  = d;
      step();
      coram_we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      RST = 1'b0;
      ext_write_data = '0;
      ext_write_ch = '0;
      ext_write_empty = 1'b0;
      ext_read_almost_full = 1'b0;
      coram_ch = '0;
      coram_d = '0;
      coram_we = 1'b0;
      coram_re = 1'b0;
      last_q = '0;

      // Reset state, with a non-empty upstream FIFO offered.
      repeat (3) step();
      @(negedge CLK);
      chk("rst_deq", ext_write_deq, 0);
      chk("rst_enq", ext_read_enq, 0);
      chk("rst_q_valid", coram_q_valid, 0);
      chk("rst_q", coram_q, 0);
      chk("rst_rdata", {ext_read_ch, ext_read_data}, 0);
      chk("rst_status", {coram_rx_avail, coram_tx_busy, coram_tx_overflow}, 0);
      step();
      ext_write_empty = 1'b1;
      RST = 1'b1;
      step();

      // In-order inbound transfer with one-cycle read latency.
      for (int i = 0; i < 4; i++) ext_push(2'd1, 32'hA0 + 32'(i), "t1_deq");
      ext_write_empty = 1'b1;
      @(negedge CLK);
      chk("t1_avail", coram_rx_avail, 4'b0010);
      step();
      for (int i = 0; i < 4; i++) coram_read(2'd1, 32'hA0 + 32'(i));
      wait_drain("t1_drain");
      @(negedge CLK);
      chk("t1_avail_after", coram_rx_avail, 4'b0000);
      step();

      // Full FIFO back-pressures upstream until one word is read.
      for (int i = 0; i < 4; i++) ext_push(2'd2, 32'hB0 + 32'(i), "t2_deq");
      ext_write_data = 32'hB4;
      repeat (2) begin
         @(negedge CLK);
         chk("t2_full_deq", ext_write_deq, 0);
         step();
      end
      coram_re = 1'b1;
      coram_ch = 2'd2;
      exp_q(32'hB0);
      @(negedge CLK);
      chk("t2_pop_cycle_deq", ext_write_deq, 0);
      step();
      coram_re = 1'b0;
      @(negedge CLK);
      chk("t2_refill_deq", ext_write_deq, 1);
      step();
      ext_write_empty = 1'b1;
      for (int i = 1; i < 5; i++) coram_read(2'd2, 32'hB0 + 32'(i));
      wait_drain("t2_drain");

      // Simultaneous push and pop on one channel.
      ext_push(2'd0, 32'hC0, "t21_deq0");
      ext_write_empty = 1'b0;
      ext_write_ch = 2'd0;
      ext_write_data = 32'hC1;
      coram_re = 1'b1;
      coram_ch = 2'd0;
      exp_q(32'hC0);
      @(negedge CLK);
      chk("t21_deq1", ext_write_deq, 1);
      step();
      ext_write_empty = 1'b1;
      coram_re = 1'b0;
      @(negedge CLK);
      chk("t21_avail", coram_rx_avail, 4'b0001);
      step();
      coram_read(2'd0, 32'hC1);
      wait_drain("t21_drain");

      // Read of an empty channel returns nothing and holds coram_q.
      coram_re = 1'b1;
      coram_ch = 2'd0;
      step();
      coram_re = 1'b0;
      @(negedge CLK);
      chk("t5_q_valid", coram_q_valid, 0);
      chk("t5_q_held", coram_q, last_q);
      step();

      // Two slots filled under backpressure, released: ch0 then ch3 back-to-back.
      ext_read_almost_full = 1'b1;
      coram_write(2'd0, 32'h11);
      coram_write(2'd3, 32'h33);
      step();
      @(negedge CLK);
      chk("t3_busy", coram_tx_busy, 4'b1001);
      step();
      ext_read_almost_full = 1'b0;
      exp_rd(1, 2'd0, 32'h11);
      exp_rd(2, 2'd3, 32'h33);
      wait_drain("t3_drain");
      @(negedge CLK);
      chk("t3_busy_after", coram_tx_busy, 4'b0000);
      step();

      // Write to an occupied slot is dropped and flagged sticky.
      ext_read_almost_full = 1'b1;
      coram_write(2'd1, 32'h55);
      coram_write(2'd1, 32'h66);
      @(negedge CLK);
      chk("t4_overflow", coram_tx_overflow, 4'b0010);
      chk("t4_busy", coram_tx_busy, 4'b0010);
      step();
      ext_read_almost_full = 1'b0;
      exp_rd(1, 2'd1, 32'h55);
      wait_drain("t4_drain");
      repeat (3) step();
      @(negedge CLK);
      chk("t4_overflow_sticky", coram_tx_overflow, 4'b0010);
      step();

      // Refill of a slot in the cycle it is granted is accepted.
      exp_rd(2, 2'd2, 32'h77);
      coram_write(2'd2, 32'h77);
      exp_rd(2, 2'd2, 32'h78);
      coram_write(2'd2, 32'h78);
      wait_drain("t29_drain");
      @(negedge CLK);
      chk("t29_overflow", coram_tx_overflow, 4'b0010);
      chk("t29_busy", coram_tx_busy, 4'b0000);
      step();

      // Reset with buffered inbound words and a busy outbound slot.
      for (int i = 0; i < 3; i++) ext_push(2'd1, 32'hD0 + 32'(i), "t6_deq");
      ext_write_empty = 1'b1;
      ext_read_almost_full = 1'b1;
      coram_write(2'd2, 32'h99);
      @(negedge CLK);
      chk("t6_avail_pre", coram_rx_avail, 4'b0010);
      chk("t6_busy_pre", coram_tx_busy, 4'b0100);
      step();
      RST = 1'b0;
      ext_write_empty = 1'b0;
      @(negedge CLK);
      chk("t6_rst_deq", ext_write_deq, 0);
      step();
      @(negedge CLK);
      chk("t6_status", {coram_rx_avail, coram_tx_busy, coram_tx_overflow}, 0);
      chk("t6_q", {coram_q_valid, coram_q}, 0);
      chk("t6_read", {ext_read_enq, ext_read_ch, ext_read_data}, 0);
      step();
      RST = 1'b1;
      ext_write_empty = 1'b1;
      ext_read_almost_full = 1'b0;
      coram_re = 1'b1;
      coram_ch = 2'd1;
      step();
      coram_re = 1'b0;
      @(negedge CLK);
      chk("t6_discarded_q_valid", coram_q_valid, 0);
      step();
      repeat (4) step();
      @(negedge CLK);
      chk("t6_busy_after", coram_tx_busy, 4'b0000);
      step();
      wait_drain("final_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
